noc_ni_tx: RTL and testbench

//  Transmit network interface for one NOC node. Buffers payload words from the local core.
//  On a send command, packetizes them into 16-bit flits: header, then payload.

---
 rtl/noc_ni_tx.sv | 187 ++++++++++++++++++
 tb/tb_noc_ni_tx.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_ni_tx.sv
// Transmit network interface for one NOC node.
// Core payload words are buffered in a FIFO. A send command is accepted only
// once the whole payload is buffered (store-and-forward). The packet then goes
// out as 16-bit flits: one header, then the payload words.
// Optional feature macro: NOC_NI_CHECKSUM_EN appends a tail flit carrying the
// XOR of the header and all payload flits. With the tail present, flit_last
// marks the tail flit only.
module noc_ni_tx #(
  parameter logic [3:0] SRC_ID     = 4'd0,
  parameter int         FIFO_DEPTH = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_valid,
  output logic                              wr_ready,
  input  logic [15:0]                       wr_data,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [3:0]                        cmd_dest,
  input  logic [3:0]                        cmd_len,
  output logic                              flit_valid,
  input  logic                              flit_ready,
  output logic [15:0]                       flit_data,
  output logic                              flit_last,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HEAD = 2'd1;
  localparam logic [1:0] ST_BODY = 2'd2;
`ifdef NOC_NI_CHECKSUM_EN
  localparam logic [1:0] ST_TAIL = 2'd3;
  localparam bit         TAIL_EN = 1'b1;
`else
  localparam bit         TAIL_EN = 1'b0;
`endif

  // Payload FIFO storage and pointers
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  logic [15:0]   head_word;

  // Packetizer state
  logic [1:0]    state_q, state_d;
  logic          valid_q, valid_d;
  logic [15:0]   data_q, data_d;
  logic          last_q, last_d;
  logic [3:0]    rem_q, rem_d;
  logic [3:0]    seq_q, seq_d;
  logic [15:0]   csum_q, csum_d;
  logic          xfer;
  logic [15:0]   header;

  assign wr_ready   = (count_q != CW'(FIFO_DEPTH));
  assign push       = wr_valid & wr_ready;
  assign head_word  = mem_q[rptr_q];
  assign xfer       = valid_q & flit_ready;
  assign cmd_ready  = (state_q == ST_IDLE) && (count_q >= CW'(cmd_len));
  assign header     = {cmd_dest, SRC_ID, cmd_len, seq_q};

  assign flit_valid = valid_q;
  assign flit_data  = data_q;
  assign flit_last  = last_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != ST_IDLE);

  // FIFO storage write; contents need no reset since count gates all reads
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end

  // FIFO pointer and occupancy next-state; simultaneous push/pop keeps count
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Packetizer FSM: header, payload words back-to-back, optional tail
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    rem_d   = rem_q;
    seq_d   = seq_q;
    csum_d  = csum_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          data_d  = header;
          valid_d = 1'b1;
          last_d  = !TAIL_EN && (cmd_len == 4'd0);
          rem_d   = cmd_len;
          csum_d  = header;
          state_d = ST_HEAD;
        end
      end
      ST_HEAD, ST_BODY: begin
        if (xfer) begin
          // rem_q counts words not yet sent, including the one on the bus in BODY
          if ((state_q == ST_HEAD) ? (rem_q != 4'd0) : (rem_q > 4'd1)) begin
            pop     = 1'b1;
            data_d  = head_word;
            csum_d  = csum_q ^ head_word;
            if (state_q == ST_HEAD) begin
              last_d = !TAIL_EN && (rem_q == 4'd1);
            end else begin
              last_d = !TAIL_EN && (rem_q == 4'd2);
              rem_d  = rem_q - 4'd1;
            end
            state_d = ST_BODY;
          end else begin
`ifdef NOC_NI_CHECKSUM_EN
            data_d  = csum_q;
            last_d  = 1'b1;
            state_d = ST_TAIL;
`else
            valid_d = 1'b0;
            last_d  = 1'b0;
            seq_d   = seq_q + 4'd1;
            state_d = ST_IDLE;
`endif
          end
        end
      end
`ifdef NOC_NI_CHECKSUM_EN
      ST_TAIL: begin
        if (xfer) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          seq_d   = seq_q + 4'd1;
          state_d = ST_IDLE;
        end
      end
`endif
      default: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset empties the FIFO and aborts any packet in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      rem_q   <= '0;
      seq_q   <= '0;
      csum_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      rem_q   <= rem_d;
      seq_q   <= seq_d;
      csum_q  <= csum_d;
    end
  end

endmodule

// File: tb/tb_noc_ni_tx.sv
// Scoreboard bench for noc_ni_tx (SRC_ID=2, FIFO_DEPTH=16).
// The reference model keeps the buffered payload as a queue of words and,
// when a command is accepted, appends the complete expected flit sequence to
// the scoreboard. A separate monitor pops and compares every transferred flit.
module tb_noc_ni_tx;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] wr_data = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_dest = '0;
  logic [3:0]  cmd_len = '0;
  logic        flit_valid;
  logic        flit_ready = 1'b1;
  logic [15:0] flit_data;
  logic        flit_last;
  logic [4:0]  fifo_count;
  logic        busy;

  noc_ni_tx #(.SRC_ID(4'd2), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dest(cmd_dest), .cmd_len(cmd_len),
    .flit_valid(flit_valid), .flit_ready(flit_ready),
    .flit_data(flit_data), .flit_last(flit_last),
    .fifo_count(fifo_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        last;
    bit          payload;
  } flit_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_acc    = 0;
  logic [15:0] mq[$];
  flit_t       sb[$];
  logic [3:0]  seq_m = '0;
  bit          pending_hdr = 1'b0;
  int          rdy_mode = 0;
  bit          stream = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: occupancy, handshake readiness and packet expectation
  always @(negedge clk) begin
    int          unpop;
    int          exp_count;
    bit          exp_wr_rdy;
    bit          exp_cmd_rdy;
    logic [15:0] hdr, csum, w;
    flit_t       f;
    if (!rst) begin
      unpop = 0;
      for (int i = 1; i < sb.size(); i++) if (sb[i].payload) unpop++;
      exp_count   = mq.size() + unpop;
      exp_wr_rdy  = (exp_count != DEPTH);
      exp_cmd_rdy = (sb.size() == 0) && (mq.size() >= int'(cmd_len));
      chk("fifo_count", 32'(fifo_count), 32'(exp_count));
      chk("wr_ready", 32'(wr_ready), 32'(exp_wr_rdy));
      chk("cmd_ready", 32'(cmd_ready), 32'(exp_cmd_rdy));
      chk("busy", 32'(busy), 32'(sb.size() != 0));
      if (cmd_valid && exp_cmd_rdy) begin
        hdr = {cmd_dest, 4'd2, cmd_len, seq_m};
        csum = hdr;
        f.data = hdr; f.payload = 1'b0;
`ifdef NOC_NI_CHECKSUM_EN
        f.last = 1'b0;
`else
        f.last = (cmd_len == 4'd0);
`endif
        sb.push_back(f);
        for (int k = 0; k < int'(cmd_len); k++) begin
          w = mq.pop_front();
          csum ^= w;
          f.data = w; f.payload = 1'b1;
`ifdef NOC_NI_CHECKSUM_EN
          f.last = 1'b0;
`else
          f.last = (k == int'(cmd_len) - 1);
`endif
          sb.push_back(f);
        end
`ifdef NOC_NI_CHECKSUM_EN
        f.data = csum; f.payload = 1'b0; f.last = 1'b1;
        sb.push_back(f);
`endif
        seq_m = seq_m + 4'd1;
        pending_hdr = 1'b1;
        n_acc++;
      end
      if (wr_valid && exp_wr_rdy) mq.push_back(wr_data);
    end
  end

  // Monitor: compares each transferred flit against the scoreboard head
  always begin
    flit_t f;
    @(negedge clk);
    #2;
    if (!rst) begin
      if (pending_hdr) begin
        chk("valid_before_header", 32'(flit_valid), 32'd0);
        pending_hdr = 1'b0;
      end else begin
        chk("flit_valid", 32'(flit_valid), 32'(sb.size() != 0));
        if (flit_valid && flit_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_flit", 32'(flit_data), 32'hFFFF_FFFF);
          end else begin
            f = sb.pop_front();
            chk("flit_data", 32'(flit_data), 32'(f.data));
            chk("flit_last", 32'(flit_last), 32'(f.last));
          end
        end
      end
    end
  end

  // Sink readiness pattern and optional continuous write stream
  always begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       flit_ready = 1'b1;
      1:       flit_ready = ~flit_ready;
      default: flit_ready = 1'($urandom_range(0, 1));
    endcase
    if (stream) begin
      wr_valid = 1'b1;
      wr_data  = 16'($urandom);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [15:0] w);
    wr_valid = 1'b1;
    wr_data  = w;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic cmd_issue(input logic [3:0] d, input logic [3:0] l);
    cmd_valid = 1'b1;
    cmd_dest  = d;
    cmd_len   = l;
  endtask

  task automatic cmd_wait(input int a0);
    int i;
    i = 0;
    while (n_acc == a0 && i < 300) begin
      tick();
      i++;
    end
    if (n_acc == a0) chk("cmd_accept_timeout", 32'd0, 32'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic send(input logic [3:0] d, input logic [3:0] l);
    int a0;
    a0 = n_acc;
    cmd_issue(d, l);
    cmd_wait(a0);
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (sb.size() != 0 && i < 500) begin
      tick();
      i++;
    end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int n, l;
    // Reset values
    #3;
    chk("rst_flit_valid", 32'(flit_valid), 32'd0);
    chk("rst_flit_data", 32'(flit_data), 32'd0);
    chk("rst_flit_last", 32'(flit_last), 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Basic packet, then a second one carrying seq=1
    write_word(16'h1111);
    write_word(16'h2222);
    write_word(16'h3333);
    send(4'd5, 4'd3);
    drain();
    write_word(16'hABCD);
    send(4'd5, 4'd1);
    drain();

    // Backpressure with alternating ready
    rdy_mode = 1;
    write_word(16'h1111);
    write_word(16'h2222);
    write_word(16'h3333);
    send(4'd5, 4'd3);
    drain();
    rdy_mode = 0;

    // Insufficient data: command waits for the 4th word
    write_word(16'hA001);
    write_word(16'hA002);
    a0 = n_acc;
    cmd_issue(4'd3, 4'd4);
    repeat (4) tick();
    write_word(16'hA003);
    tick();
    write_word(16'hA004);
    cmd_wait(a0);
    drain();

    // Zero length
    send(4'd15, 4'd0);
    drain();

    // Payload pattern used for the checksum tail
    write_word(16'h00FF);
    write_word(16'h0F0F);
    send(4'd6, 4'd2);
    drain();

    // FIFO full: 17 writes, the last one dropped
    for (int i = 0; i < 17; i++) write_word(16'hC000 + 16'(i));
    tick();
    // Long packet while the core keeps writing
    stream = 1'b1;
    send(4'd9, 4'd15);
    drain();
    stream = 1'b0;
    tick();
    wr_valid = 1'b0;
    send(4'd10, 4'd15);
    drain();

    // Reset in the middle of a payload
    write_word(16'h7001);
    write_word(16'h7002);
    write_word(16'h7003);
    write_word(16'h7004);
    send(4'd7, 4'd4);
    tick();
    tick();
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_flit_valid", 32'(flit_valid), 32'd0);
    chk("midrst_fifo_count", 32'(fifo_count), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    sb.delete();
    mq.delete();
    seq_m = '0;
    pending_hdr = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    write_word(16'h0BEE);
    send(4'd1, 4'd1);
    drain();

    // Randomized packets with random sink readiness
    rdy_mode = 2;
    for (int p = 0; p < 40; p++) begin
      n = $urandom_range(0, 15);
      for (int i = 0; i < n; i++) write_word(16'($urandom));
      l = (mq.size() > 15) ? 15 : mq.size();
      l = $urandom_range(0, l);
      send(4'($urandom_range(0, 15)), 4'(l));
      drain();
    end
    rdy_mode = 0;
    repeat (3) tick();
    chk("final_scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
